// File: rtl/uart_tx_scheduler_if.sv
// Requester-side and UART-side signal bundle for uart_tx_scheduler.
// The master drives requests and observes the scheduler; the slave is the scheduler itself.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [2*NUM_REQ-1:0] req_baud;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic [7:0]           data_out;
  logic [1:0]           baud_sel_out;
  logic                 start;
  logic                 busy;

  modport master (
    output req, req_data, req_baud,
    input  gnt, done, data_out, baud_sel_out, start, busy
  );

  modport slave (
    input  req, req_data, req_baud,
    output gnt, done, data_out, baud_sel_out, start, busy
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ requesters:
// latches a winner's byte/baud, settles on a baud change, holds start for one frame.
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int FRAME_TICKS  = 11,
  parameter int SETTLE_TICKS = 2
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  baud_tick,
  uart_tx_scheduler_if.slave    bus
);

  localparam int          MAX_TICKS = (FRAME_TICKS > SETTLE_TICKS) ? FRAME_TICKS : SETTLE_TICKS;
  localparam int          CNT_W     = $clog2(MAX_TICKS + 1);
  localparam int          IDX_W     = $clog2(NUM_REQ);
  localparam int unsigned NREQ_U    = NUM_REQ;

  localparam logic [CNT_W-1:0] FRAME_LAST  = CNT_W'(FRAME_TICKS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SEND,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [7:0]           data_q, data_d;
  logic [1:0]           baud_q, baud_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     win_q, win_d;

  logic                 found;
  logic [IDX_W-1:0]     arb_idx;
  int unsigned          scan;
  logic [IDX_W-1:0]     scan_idx;

  // Round-robin scan starting at ptr; the first requester found wins.
  always_comb begin
    found    = 1'b0;
    arb_idx  = '0;
    scan     = 0;
    scan_idx = '0;
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      scan     = (32'(ptr_q) + i) % NREQ_U;
      scan_idx = IDX_W'(scan);
      if (!found && bus.req[scan_idx]) begin
        found   = 1'b1;
        arb_idx = scan_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    baud_d  = baud_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = NUM_REQ'(1) << arb_idx;
          win_d   = arb_idx;
          data_d  = bus.req_data[{arb_idx, 3'b000} +: 8];
          baud_d  = bus.req_baud[{arb_idx, 1'b0} +: 2];
          cnt_d   = '0;
          state_d = (baud_d != baud_q) ? SETTLE : SEND;
        end
      end

      SETTLE: begin
        if (baud_tick) begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = SEND;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      SEND: begin
        if (baud_tick) begin
          if (cnt_q == FRAME_LAST) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        ptr_d   = (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      data_q  <= '0;
      baud_q  <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      baud_q  <= baud_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
    end
  end

  // start and done are decoded from the registered state, so they move on the same edge as busy/gnt.
  assign bus.gnt          = gnt_q;
  assign bus.done         = (state_q == DONE) ? gnt_q : '0;
  assign bus.data_out     = data_q;
  assign bus.baud_sel_out = baud_q;
  assign bus.start        = (state_q == SEND);
  assign bus.busy         = (state_q != IDLE);

endmodule
